piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4, parallel word width in bits; legal range 1..64.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 is serialised first, 0 = bit 0 is serialised first.
REQ-003 Parameter IDLE_LEVEL, default 0, value driven on serial_out when no word is being shifted.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low; rst=0 resets the block.
REQ-006 load_valid  input  1  parallel_in holds a word offered for loading.
REQ-007 parallel_in  input  WIDTH  word to serialise; sampled only on an accepted load.
REQ-008 load_ready  output  1  block can accept a word this cycle.
REQ-009 shift_en  input  1  downstream consumes the current serial bit this cycle; 0 stalls.
REQ-010 serial_out  output  1  current serial bit.
REQ-011 serial_valid  output  1  serial_out carries a data bit.
REQ-012 last  output  1  current serial bit is the final bit of its word.
REQ-013 busy  output  1  a word is in progress.

Function
REQ-014 FSM states: IDLE and SHIFT; busy = (state == SHIFT); serial_valid = busy.
REQ-015 Accept = load_valid && load_ready at a rising edge; on accept: shift register <= parallel_in, bit counter <= 0, state <= SHIFT.
REQ-016 load_ready = IDLE || (SHIFT && last && shift_en); combinational, no other path.
REQ-017 load_valid while SHIFT and not (last && shift_en): ignored; parallel_in not sampled, no state change.
REQ-018 Latency: first bit of an accepted word is on serial_out in the cycle immediately after the accepting edge.
REQ-019 In SHIFT, serial_out = shift register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0), driven from registers only.
REQ-020 Bit consumed = SHIFT && shift_en at a rising edge; on consume the register shifts one place toward the output end and the counter increments.
REQ-021 SHIFT && !shift_en: register, counter, state and all outputs held unchanged (stall of any length).
REQ-022 last = SHIFT && (counter == WIDTH-1); counter width max(1, $clog2(WIDTH)), never exceeds WIDTH-1.
REQ-023 Consume while last=1 with an accepted load: new word loaded, counter <= 0, stay in SHIFT (back-to-back, no gap cycle).
REQ-024 Consume while last=1 without load_valid: state <= IDLE.
REQ-025 In IDLE: serial_out = IDLE_LEVEL, serial_valid = 0, last = 0; shift_en ignored.
REQ-026 WIDTH=1: last=1 in every SHIFT cycle; each word occupies exactly one consume.
REQ-027 Exactly WIDTH consumes per accepted word; no bit dropped, duplicated or reordered.

Reset
REQ-028 rst=0 forces immediately, independent of clk: state=IDLE, counter=0, shift register=0, serial_out=IDLE_LEVEL, serial_valid=0, last=0, busy=0, load_ready=1.
REQ-029 Reset asserted mid-word aborts that word; no remaining bit is emitted after rst returns to 1.
REQ-030 First accept possible at the first rising edge with rst=1.

Verification
REQ-031 WIDTH=4, MSB_FIRST=1, shift_en=1, load 4'b1010 -> serial_out 1,0,1,0 on the next 4 cycles, last only on 4th, then IDLE, serial_out=0.
REQ-032 MSB_FIRST=0, load 4'b1100, shift_en=1 -> serial_out 0,0,1,1; serial_valid high exactly 4 cycles.
REQ-033 Load 4'b1010, then hold load_valid with 4'b1100 -> load_ready high only in the last-bit cycle; stream 1,0,1,0,1,1,0,0 with no gap.
REQ-034 Load 4'b1010, shift_en=0 for 3 cycles after 2nd bit -> serial_out held at 0, last=0, counter unchanged; resumes 1,0.
REQ-035 rst=0 asserted between clock edges during 3rd bit -> outputs reach reset values before the next edge; after release no residual bits.
REQ-036 WIDTH=1, load_valid held with alternating 1/0 -> serial_out 1,0,1,0 with last=1 and load_ready=1 every cycle.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Handshake and serial-side signals of the parallel-in/serial-out serializer.
// The master side offers words and consumes bits; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic [WIDTH-1:0] parallel_in;
    logic             load_ready;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             last;
    logic             busy;

    modport master (
        output load_valid, parallel_in, shift_en,
        input  load_ready, serial_out, serial_valid, last, busy
    );

    modport slave (
        input  load_valid, parallel_in, shift_en,
        output load_ready, serial_out, serial_valid, last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with a load handshake and per-bit consume strobe.
// Words may be loaded back-to-back during the last bit of the previous word.
module piso_serializer #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    piso_serializer_if.slave  bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_last;
    logic             r_serial;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_shreg_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_last_next;
    logic             w_serial_next;
    logic             w_consume;
    logic             w_load_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_shifted;

    assign w_shifted = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);

    // r_last is only ever set in SHIFT, so it already qualifies the state.
    always_comb begin
        w_consume     = (r_state == SHIFT) && bus.shift_en;
        w_load_ready  = (r_state == IDLE) || (r_last && bus.shift_en);
        w_accept      = bus.load_valid && w_load_ready;
        w_state_next  = r_state;
        w_shreg_next  = r_shreg;
        w_cnt_next    = r_cnt;
        w_last_next   = r_last;
        if (w_accept) begin
            w_state_next = SHIFT;
            w_shreg_next = bus.parallel_in;
            w_cnt_next   = '0;
            w_last_next  = (WIDTH == 1);
        end else if (w_consume) begin
            if (r_last) begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
                w_last_next  = 1'b0;
            end else begin
                w_shreg_next = w_shifted;
                w_cnt_next   = r_cnt + CW'(1);
                w_last_next  = ((r_cnt + CW'(1)) == LAST_CNT);
            end
        end
        // Serial bit is precomputed from next state so the output comes straight from a flop.
        if (w_state_next == SHIFT) begin
            w_serial_next = MSB_FIRST ? w_shreg_next[WIDTH-1] : w_shreg_next[0];
        end else begin
            w_serial_next = IDLE_LEVEL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_last   <= 1'b0;
            r_serial <= IDLE_LEVEL;
        end else begin
            r_state  <= w_state_next;
            r_shreg  <= w_shreg_next;
            r_cnt    <= w_cnt_next;
            r_last   <= w_last_next;
            r_serial <= w_serial_next;
        end
    end

    assign bus.load_ready   = w_load_ready;
    assign bus.serial_out   = r_serial;
    assign bus.serial_valid = (r_state == SHIFT);
    assign bus.busy         = (r_state == SHIFT);
    assign bus.last         = r_last;
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (MSB-first, LSB-first with idle-high, 1-bit)
// checked every cycle against a bit-queue model plus literal stream expectations.
module tb_piso_serializer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    piso_serializer_if #(.WIDTH(4)) ifa ();
    piso_serializer_if #(.WIDTH(4)) ifb ();
    piso_serializer_if #(.WIDTH(1)) ifc ();

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flattened views of the three instances so the model and checker can loop.
    logic        lv_w   [3];
    logic [63:0] pin_w  [3];
    logic        sen_w  [3];
    logic        so_w   [3];
    logic        sv_w   [3];
    logic        last_w [3];
    logic        busy_w [3];
    logic        rdy_w  [3];

    assign lv_w[0] = ifa.load_valid;  assign pin_w[0] = 64'(ifa.parallel_in);  assign sen_w[0] = ifa.shift_en;
    assign lv_w[1] = ifb.load_valid;  assign pin_w[1] = 64'(ifb.parallel_in);  assign sen_w[1] = ifb.shift_en;
    assign lv_w[2] = ifc.load_valid;  assign pin_w[2] = 64'(ifc.parallel_in);  assign sen_w[2] = ifc.shift_en;
    assign so_w[0] = ifa.serial_out;  assign sv_w[0] = ifa.serial_valid; assign last_w[0] = ifa.last;
    assign so_w[1] = ifb.serial_out;  assign sv_w[1] = ifb.serial_valid; assign last_w[1] = ifb.last;
    assign so_w[2] = ifc.serial_out;  assign sv_w[2] = ifc.serial_valid; assign last_w[2] = ifc.last;
    assign busy_w[0] = ifa.busy;      assign rdy_w[0] = ifa.load_ready;
    assign busy_w[1] = ifb.busy;      assign rdy_w[1] = ifb.load_ready;
    assign busy_w[2] = ifc.busy;      assign rdy_w[2] = ifc.load_ready;

    // Model: bits still to be emitted, next bit at position 0, plus how many remain.
    int          wid  [3] = '{4, 4, 1};
    bit          msbf [3] = '{1'b1, 1'b0, 1'b1};
    bit          idl  [3] = '{1'b0, 1'b1, 1'b0};
    logic [63:0] m_bits [3];
    int          m_cnt  [3];

    logic [63:0] out_log  [3];
    logic [63:0] last_log [3];
    logic [63:0] rdy_log  [3];
    int          n_log    [3];

    function automatic logic [63:0] order_bits(input logic [63:0] p, input int w, input bit msb);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < w; k++) r[k] = msb ? p[w-1-k] : p[k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 3; i++) begin
            out_log[i] = '0; last_log[i] = '0; rdy_log[i] = '0; n_log[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_bits[i] = '0; end
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    bit ready;
                    ready = (m_cnt[i] == 0) || (m_cnt[i] == 1 && sen_w[i]);
                    if (m_cnt[i] > 0 && sen_w[i]) begin
                        m_bits[i] = m_bits[i] >> 1;
                        m_cnt[i]  = m_cnt[i] - 1;
                    end
                    if (lv_w[i] && ready) begin
                        m_bits[i] = order_bits(pin_w[i], wid[i], msbf[i]);
                        m_cnt[i]  = wid[i];
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                logic e_busy;
                e_busy = (m_cnt[i] > 0);
                chk($sformatf("serial_out[%0d]", i),   64'(so_w[i]),   64'(e_busy ? m_bits[i][0] : idl[i]));
                chk($sformatf("serial_valid[%0d]", i), 64'(sv_w[i]),   64'(e_busy));
                chk($sformatf("busy[%0d]", i),         64'(busy_w[i]), 64'(e_busy));
                chk($sformatf("last[%0d]", i),         64'(last_w[i]), 64'(m_cnt[i] == 1));
                chk($sformatf("load_ready[%0d]", i),   64'(rdy_w[i]),
                    64'((m_cnt[i] == 0) || (m_cnt[i] == 1 && sen_w[i])));
                if (sv_w[i]) begin
                    out_log[i]  = {out_log[i][62:0], so_w[i]};
                    last_log[i] = {last_log[i][62:0], last_w[i]};
                    rdy_log[i]  = {rdy_log[i][62:0], rdy_w[i]};
                    n_log[i]++;
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ifa.load_valid = 1'b0; ifa.parallel_in = '0; ifa.shift_en = 1'b1;
        ifb.load_valid = 1'b0; ifb.parallel_in = '0; ifb.shift_en = 1'b1;
        ifc.load_valid = 1'b0; ifc.parallel_in = '0; ifc.shift_en = 1'b1;
        clear_logs();
        #2 rst = 1'b0;
        #1;
        chk("rst a serial_out", 64'(ifa.serial_out), 64'd0);
        chk("rst b serial_out", 64'(ifb.serial_out), 64'd1);
        chk("rst a load_ready", 64'(ifa.load_ready), 64'd1);
        chk("rst a busy",       64'(ifa.busy),       64'd0);
        tick();
        tick();
        rst = 1'b1;

        // Plain words on both 4-bit instances, loaded at the first edge out of reset.
        clear_logs();
        ifa.load_valid = 1'b1; ifa.parallel_in = 4'b1010;
        ifb.load_valid = 1'b1; ifb.parallel_in = 4'b1100;
        tick();
        ifa.load_valid = 1'b0; ifb.load_valid = 1'b0;
        repeat (6) tick();
        chk("a stream 1010", out_log[0], 64'b1010);
        chk("a last pos",    last_log[0], 64'b0001);
        chk("a bit count",   64'(n_log[0]), 64'd4);
        chk("b stream lsb",  out_log[1], 64'b0011);
        chk("b valid count", 64'(n_log[1]), 64'd4);
        chk("a idle level",  64'(ifa.serial_out), 64'd0);
        chk("b idle level",  64'(ifb.serial_out), 64'd1);

        // Back-to-back: second word held waiting until the last bit of the first.
        clear_logs();
        ifa.load_valid = 1'b1; ifa.parallel_in = 4'b1010;
        tick();
        ifa.parallel_in = 4'b1100;
        repeat (4) tick();
        ifa.load_valid = 1'b0;
        repeat (5) tick();
        chk("b2b stream", out_log[0], 64'b10101100);
        chk("b2b ready",  rdy_log[0], 64'b00010001);
        chk("b2b count",  64'(n_log[0]), 64'd8);

        // Stall for three edges while the second bit is showing.
        clear_logs();
        ifa.load_valid = 1'b1; ifa.parallel_in = 4'b1010;
        tick();
        ifa.load_valid = 1'b0;
        tick();
        ifa.shift_en = 1'b0;
        repeat (3) tick();
        ifa.shift_en = 1'b1;
        repeat (4) tick();
        chk("stall stream", out_log[0], 64'b1000010);
        chk("stall last",   last_log[0], 64'b0000001);
        chk("stall count",  64'(n_log[0]), 64'd7);

        // Asynchronous reset in the middle of the third bit.
        ifa.load_valid = 1'b1; ifa.parallel_in = 4'b1010;
        tick();
        ifa.load_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("async rst valid",  64'(ifa.serial_valid), 64'd0);
        chk("async rst out",    64'(ifa.serial_out),   64'd0);
        chk("async rst last",   64'(ifa.last),         64'd0);
        chk("async rst ready",  64'(ifa.load_ready),   64'd1);
        tick();
        rst = 1'b1;
        clear_logs();
        repeat (4) tick();
        chk("no residual bits", 64'(n_log[0]), 64'd0);

        // One-bit words streamed continuously.
        clear_logs();
        ifc.load_valid = 1'b1; ifc.parallel_in = 1'b1;
        tick();
        ifc.parallel_in = 1'b0;
        tick();
        ifc.parallel_in = 1'b1;
        tick();
        ifc.parallel_in = 1'b0;
        tick();
        ifc.load_valid = 1'b0;
        repeat (2) tick();
        chk("w1 stream", out_log[2], 64'b1010);
        chk("w1 last",   last_log[2], 64'b1111);
        chk("w1 ready",  rdy_log[2], 64'b1111);
        chk("w1 count",  64'(n_log[2]), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
